// File: rtl/bcd_seg_source.sv
// bcd_seg_source: converts a 0..99 binary value to two active-low 7-segment
// digit patterns by iterative double-dabble (one shift per clock). Values above
// 99 display dashes. The tens digit can be blanked when it is zero, and the
// whole display can be blinked with a programmable half-period.
//
// Handshake: load is a single-cycle request, accepted only on an edge where
// the FSM is in IDLE (busy=0 and not in UPDATE). Loads at other times are
// dropped, not queued. done pulses for one cycle when new segment values
// appear on seg0/seg1.
module bcd_seg_source #(
   parameter int BLINK_HALF = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [6:0] value,
   input  logic       blank_lz,
   input  logic       blink_en,
   output logic       busy,
   output logic       done,
   output logic [6:0] seg0,
   output logic [6:0] seg1,
   output logic [1:0] state_dbg
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam int         CW        = $clog2(BLINK_HALF);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [6:0]      bin_sr;
   logic [7:0]      bcd;
   logic [2:0]      iter;
   logic            lz_q;
   logic            oor_q;
   logic [6:0]      disp0, disp1;
   logic            done_q;
   logic [CW-1:0]   blink_cnt;
   logic            phase;
   logic [7:0]      bcd_adj;

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic: SHIFT lingers one cycle with iter==0 before UPDATE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load) state_nx = SHIFT;
         SHIFT:   if (iter == 3'd0) state_nx = UPDATE;
         UPDATE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM-derived outputs
   always_comb begin
      busy      = (state == SHIFT);
      state_dbg = state;
   end

   // Add-3 correction applied to each BCD nibble before the shift
   always_comb begin
      bcd_adj = bcd;
      if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
   end

   // Conversion datapath, display registers and done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_sr <= '0;
         bcd    <= '0;
         iter   <= '0;
         lz_q   <= 1'b0;
         oor_q  <= 1'b0;
         disp0  <= SEG_BLANK;
         disp1  <= SEG_BLANK;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  bin_sr <= value;
                  bcd    <= '0;
                  iter   <= 3'd7;
                  lz_q   <= blank_lz;
                  oor_q  <= (value > 7'd99);
               end
            end
            SHIFT: begin
               if (iter != 3'd0) begin
                  bcd    <= {bcd_adj[6:0], bin_sr[6]};
                  bin_sr <= {bin_sr[5:0], 1'b0};
                  iter   <= iter - 3'd1;
               end
            end
            UPDATE: begin
               done_q <= 1'b1;
               if (oor_q) begin
                  disp0 <= SEG_DASH;
                  disp1 <= SEG_DASH;
               end else begin
                  disp0 <= encode(bcd[3:0]);
                  disp1 <= (lz_q && bcd[7:4] == 4'd0) ? SEG_BLANK : encode(bcd[7:4]);
               end
            end
            default: ;
         endcase
      end
   end

   // Blink timebase: counter and phase held at zero while blinking is off
   always_ff @(posedge clk) begin
      if (reset || !blink_en) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == CW'(BLINK_HALF - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Blink gating on the registered display
   always_comb begin
      done = done_q;
      seg0 = (blink_en && phase) ? SEG_BLANK : disp0;
      seg1 = (blink_en && phase) ? SEG_BLANK : disp1;
   end

endmodule

// File: tb/tb_bcd_seg_source.sv
// Bench for bcd_seg_source: fixed vector table, randomized conversions against
// a decimal-arithmetic model, plus hand sequences for ignored loads, reset
// abort and blinking.
module tb_bcd_seg_source;

   localparam int HALF = 4;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;

   logic       clk = 1'b0;
   logic       reset, load, blank_lz, blink_en;
   logic [6:0] value;
   logic       busy, done;
   logic [6:0] seg0, seg1;
   logic [1:0] state_dbg;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] seg_tab [10];

   typedef struct packed {
      logic [6:0] v;
      logic       blz;
      logic [6:0] s1;
      logic [6:0] s0;
   } vec_t;
   vec_t vecs [7];

   bcd_seg_source #(.BLINK_HALF(HALF)) dut (
      .clk(clk), .reset(reset), .load(load), .value(value),
      .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .done(done),
      .seg0(seg0), .seg1(seg1), .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: decimal digits by division, then table lookup
   task automatic model(input logic [6:0] v, input logic blz,
                        output logic [6:0] s1, output logic [6:0] s0);
      int n, tens, ones;
      n = int'(v);
      if (n > 99) begin
         s1 = DASH;
         s0 = DASH;
      end else begin
         tens = n / 10;
         ones = n % 10;
         s0 = seg_tab[ones];
         s1 = (blz && tens == 0) ? BLANK : seg_tab[tens];
      end
   endtask

   // Present load at a negedge; returns at the negedge just after the load edge
   task automatic start_load(input logic [6:0] v, input logic blz);
      value    = v;
      blank_lz = blz;
      load     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load     = 1'b0;
      value    = $urandom_range(0, 127);
      blank_lz = $urandom_range(0, 1);
   endtask

   // Full conversion with latency checks; returns at the negedge after done falls
   task automatic conv_check(input logic [6:0] v, input logic blz,
                             input logic [6:0] s1, input logic [6:0] s0);
      start_load(v, blz);
      check("busy_after_load", {6'b0, busy}, 7'd1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("busy_window", {6'b0, busy}, (k <= 7) ? 7'd1 : 7'd0);
         check("done_early", {6'b0, done}, 7'd0);
      end
      @(negedge clk);
      check("done_pulse", {6'b0, done}, 7'd1);
      check("seg1", seg1, s1);
      check("seg0", seg0, s0);
      @(negedge clk);
      check("done_fall", {6'b0, done}, 7'd0);
      check("seg1_hold", seg1, s1);
      check("seg0_hold", seg0, s0);
   endtask

   initial begin
      logic [6:0] e1, e0, rv;
      logic       rb;
      int         done_cnt, k_done;

      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;

      vecs[0] = '{v: 7'd47,  blz: 1'b0, s1: 7'b0011001, s0: 7'b1111000};
      vecs[1] = '{v: 7'd5,   blz: 1'b1, s1: 7'b1111111, s0: 7'b0010010};
      vecs[2] = '{v: 7'd5,   blz: 1'b0, s1: 7'b1000000, s0: 7'b0010010};
      vecs[3] = '{v: 7'd0,   blz: 1'b1, s1: 7'b1111111, s0: 7'b1000000};
      vecs[4] = '{v: 7'd100, blz: 1'b1, s1: 7'b0111111, s0: 7'b0111111};
      vecs[5] = '{v: 7'd127, blz: 1'b0, s1: 7'b0111111, s0: 7'b0111111};
      vecs[6] = '{v: 7'd99,  blz: 1'b0, s1: 7'b0010000, s0: 7'b0010000};

      reset = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0; blink_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Idle after reset: blank display, no activity
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_busy", {6'b0, busy}, 7'd0);
         check("idle_done", {6'b0, done}, 7'd0);
         if (i == 0 || i == 19) begin
            check("idle_seg1", seg1, BLANK);
            check("idle_seg0", seg0, BLANK);
         end
      end

      // Fixed vectors
      for (int i = 0; i < 7; i++)
         conv_check(vecs[i].v, vecs[i].blz, vecs[i].s1, vecs[i].s0);

      // Random conversions against the model
      for (int i = 0; i < 30; i++) begin
         rv = 7'($urandom_range(0, 127));
         rb = 1'($urandom_range(0, 1));
         model(rv, rb, e1, e0);
         conv_check(rv, rb, e1, e0);
      end

      // Load while busy is dropped
      start_load(7'd12, 1'b0);
      done_cnt = 0;
      k_done   = -1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         load = (k == 2);
         if (k == 2) value = 7'd34;
         if (done) begin
            done_cnt++;
            if (k_done < 0) k_done = k;
         end
      end
      check("busy_load_done_count", 7'(done_cnt), 7'd1);
      check("busy_load_latency", 7'(k_done), 7'd9);
      check("busy_load_seg1", seg1, seg_tab[1]);
      check("busy_load_seg0", seg0, seg_tab[2]);

      // Load presented during the done cycle is accepted
      start_load(7'd61, 1'b0);
      for (int k = 1; k <= 8; k++) @(negedge clk);
      @(negedge clk);
      check("chain_done", {6'b0, done}, 7'd1);
      model(7'd38, 1'b0, e1, e0);
      conv_check(7'd38, 1'b0, e1, e0);

      // Reset mid-conversion aborts with no done
      start_load(7'd56, 1'b0);
      for (int k = 1; k <= 3; k++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {6'b0, busy}, 7'd0);
      check("abort_seg1", seg1, BLANK);
      check("abort_seg0", seg0, BLANK);
      done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort_no_done", 7'(done_cnt), 7'd0);
      conv_check(7'd8, 1'b0, seg_tab[0], seg_tab[8]);

      // Blink: shown for HALF samples, blank for HALF, alternating
      conv_check(7'd23, 1'b0, seg_tab[2], seg_tab[3]);
      blink_en = 1'b1;
      for (int n = 0; n < 22; n++) begin
         if ((n / HALF) % 2 == 1) begin
            e1 = BLANK; e0 = BLANK;
         end else begin
            e1 = seg_tab[2]; e0 = seg_tab[3];
         end
         check("blink_seg1", seg1, e1);
         check("blink_seg0", seg0, e0);
         if (n == 0 || n == 5) check("blink_done", {6'b0, done}, 7'd0);
         @(negedge clk);
      end
      // n=22 is inside a blank half; drop blink_en there
      check("blink_blank_before_drop", seg0, BLANK);
      blink_en = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         check("unblink_seg1", seg1, seg_tab[2]);
         check("unblink_seg0", seg0, seg_tab[3]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_seg_source.md
Name: bcd_seg_source

Overview:
- Upstream feeder for the 2-digit multiplexed common-anode display driver. Produces its `seg0` (ones digit) and `seg1` (tens digit) inputs.
- Accepts a binary value 0..99 on a load strobe.
- Converts it sequentially to BCD with iterative double-dabble, one shift per cycle.
- Encodes each digit to active-low 7-segment patterns. Optionally blanks a leading zero and blinks the display.

Parameters:
- BLINK_HALF, 25_000_000, clock cycles per blink half-period (on time = off time); legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  single-cycle request to convert `value`; accepted only when busy=0.
- value  input  7  unsigned binary value; 0..99 legal, 100..127 out of range.
- blank_lz  input  1  sampled with load; 1 = blank the tens digit when it is 0.
- blink_en  input  1  level; 1 = display alternates shown/blank.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new segment values take effect.
- seg0  output  7  ones digit pattern {g,f,e,d,c,b,a}, active-low.
- seg1  output  7  tens digit pattern {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset forces: display registers = 7'b1111111 (blank), busy=0, done=0, FSM=IDLE, blink counter=0, blink phase=0.
  - Reset asserted mid-conversion aborts the conversion. No done pulse; display returns to blank.
- Segment encoding (active-low, bit0 = a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- FSM states:
  - IDLE: load=1 latches value into the shift register, clears the 8-bit BCD accumulator, latches blank_lz and the out-of-range flag (value>99), loads iteration count 7, and moves to SHIFT. load=0 stays in IDLE.
  - SHIFT: each cycle, add 3 to any BCD nibble >=5, then shift {bcd, bin} left by one and decrement the count. After the 7th shift, move to UPDATE.
  - UPDATE: write the display registers, assert done for this one cycle, return to IDLE.
- Latency and handshake:
  - load sampled at edge T moves the FSM to SHIFT.
  - busy=1 from T+1 through the cycle before the UPDATE edge.
  - Shifts occur at edges T+1..T+7; UPDATE is entered at T+8.
  - Display registers and done take new values at edge T+9; done falls at T+10.
  - busy is 0 in IDLE and during the UPDATE cycle, so a new load may be presented in the same cycle done is high. That load is not accepted until the FSM is back in IDLE.
  - load while busy=1 or in UPDATE is ignored; it is not queued.
  - value and blank_lz changes after the load edge have no effect on the conversion in progress.
- Result mapping:
  - Out-of-range value: seg1=seg0=dash; blank_lz ignored.
  - In range: seg0 = encode(ones), seg1 = encode(tens).
  - If latched blank_lz=1 and tens=0, seg1 = blank. seg0 is never blanked by this rule, so 0 shows as " 0".
- Blink:
  - blink_en=0: counter and phase held at 0.
  - blink_en=1: counter counts 0..BLINK_HALF-1, wraps, and toggles phase on each wrap.
  - Output seg0/seg1 = blank when (blink_en & phase), else the display registers. This gating is combinational on the registered state.
  - Deasserting blink_en clears counter and phase on the next edge, so the display is visible from then on.
  - Blink does not affect conversion or done.

Test Plan:
- Reset then idle 20 cycles: seg0=seg1=1111111, busy=0, done never asserted.
- load with value=47, blank_lz=0 at edge T: busy high T+1..T+8; done high one cycle after edge T+9; seg1=0011001, seg0=1111000.
- value=5 with blank_lz=1: seg1=1111111, seg0=0010010. Repeat with blank_lz=0: seg1=1000000. value=0 with blank_lz=1: seg0=1000000.
- value=100 and value=127: seg1=seg0=0111111 after the same 9-cycle latency. value=99: seg1=seg0=0010000.
- load of 12 followed by load of 34 three cycles later while busy: the second load is ignored and the display shows 12. Reset asserted at T+4 of a conversion: no done, outputs blank, next load of 8 yields seg0=0000000.
- BLINK_HALF=4, value 23 loaded, blink_en=1: outputs alternate 4 cycles shown (0100100/0110000) and 4 cycles blank. Dropping blink_en mid-blank shows the digits from the next edge.
